// File: rtl/branch_predictor_table.sv
// Branch direction predictor: a table of saturating counters indexed by PC
// bits, optionally hashed with global history, plus a misprediction counter.
module branch_predictor_table #(
  parameter int IDX_W = 5,
  parameter int CTR_W = 2,
  parameter int GHR_W = 0,
  parameter int CNT_W = 16,
  localparam int GW   = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_pc_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_tbl_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_tbl_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [GW-1:0]    ghr,
  output logic [CNT_W-1:0] miss_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] tbl [DEPTH];
  logic [GW-1:0]    ghr_q;
  logic [IDX_W-1:0] rd_idx;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] rd_ctr;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                input logic t);
    if (t) return (c == '1) ? c : c + CTR_W'(1);
    else   return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  generate
    if (GHR_W == 0) begin : g_bimodal
      assign rd_idx = rd_pc_idx;
    end else begin : g_gshare
      assign rd_idx = rd_pc_idx ^ IDX_W'(ghr_q);
    end
  endgenerate

  assign upd_ctr = ctr_next(tbl[upd_tbl_idx], upd_taken);
  // Same-index update in this cycle is forwarded so the read sees the new value
  assign rd_ctr  = (upd_en && (upd_tbl_idx == rd_idx)) ? upd_ctr : tbl[rd_idx];
  assign ghr     = ghr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_RST;
      ghr_q        <= '0;
      miss_count   <= '0;
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_tbl_idx <= '0;
    end else begin
      if (upd_en) begin
        tbl[upd_tbl_idx] <= upd_ctr;
        // Oldest history bit falls off the top on truncation
        if (GHR_W > 0) ghr_q <= GW'({ghr_q, upd_taken});
        if ((upd_pred != upd_taken) && (miss_count != '1))
          miss_count <= miss_count + CNT_W'(1);
      end
      pred_valid <= rd_en;
      if (rd_en) begin
        pred_taken   <= rd_ctr[CTR_W-1];
        pred_tbl_idx <= rd_idx;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench: bimodal instance (defaults) and gshare instance
// (GHR_W=3, CNT_W=2), checked against hand-computed values.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Bimodal instance
  logic       a_rst, a_rd_en, a_upd_en, a_upd_taken, a_upd_pred;
  logic [4:0] a_rd_pc_idx, a_upd_tbl_idx;
  logic       a_pred_valid, a_pred_taken;
  logic [4:0] a_pred_tbl_idx;
  logic [0:0] a_ghr;
  logic [15:0] a_miss_count;

  branch_predictor_table u_bim (
    .clk(clk), .rst(a_rst), .rd_en(a_rd_en), .rd_pc_idx(a_rd_pc_idx),
    .pred_valid(a_pred_valid), .pred_taken(a_pred_taken),
    .pred_tbl_idx(a_pred_tbl_idx), .upd_en(a_upd_en),
    .upd_tbl_idx(a_upd_tbl_idx), .upd_taken(a_upd_taken),
    .upd_pred(a_upd_pred), .ghr(a_ghr), .miss_count(a_miss_count)
  );

  // Gshare instance
  logic       b_rst, b_rd_en, b_upd_en, b_upd_taken, b_upd_pred;
  logic [4:0] b_rd_pc_idx, b_upd_tbl_idx;
  logic       b_pred_valid, b_pred_taken;
  logic [4:0] b_pred_tbl_idx;
  logic [2:0] b_ghr;
  logic [1:0] b_miss_count;

  branch_predictor_table #(.IDX_W(5), .CTR_W(2), .GHR_W(3), .CNT_W(2)) u_gsh (
    .clk(clk), .rst(b_rst), .rd_en(b_rd_en), .rd_pc_idx(b_rd_pc_idx),
    .pred_valid(b_pred_valid), .pred_taken(b_pred_taken),
    .pred_tbl_idx(b_pred_tbl_idx), .upd_en(b_upd_en),
    .upd_tbl_idx(b_upd_tbl_idx), .upd_taken(b_upd_taken),
    .upd_pred(b_upd_pred), .ghr(b_ghr), .miss_count(b_miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic rd, input logic [4:0] ridx, input logic ue,
                       input logic [4:0] uidx, input logic ut, input logic up);
    a_rd_en = rd; a_rd_pc_idx = ridx; a_upd_en = ue;
    a_upd_tbl_idx = uidx; a_upd_taken = ut; a_upd_pred = up;
  endtask

  task automatic b_set(input logic rd, input logic [4:0] ridx, input logic ue,
                       input logic [4:0] uidx, input logic ut, input logic up);
    b_rd_en = rd; b_rd_pc_idx = ridx; b_upd_en = ue;
    b_upd_tbl_idx = uidx; b_upd_taken = ut; b_upd_pred = up;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_set(1, 5'd3, 1, 5'd3, 1, 0);
    b_set(0, 5'd0, 0, 5'd0, 0, 0);
    tick(); tick();
    chk("a_rst_valid", a_pred_valid, 0);
    chk("a_rst_taken", a_pred_taken, 0);
    chk("a_rst_idx",   a_pred_tbl_idx, 0);
    chk("a_rst_miss",  a_miss_count, 0);
    chk("a_rst_ghr",   a_ghr, 0);

    // First read after reset is weakly not-taken
    a_rst = 1'b0;
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_first_valid", a_pred_valid, 1);
    chk("a_first_taken", a_pred_taken, 0);
    chk("a_first_idx",   a_pred_tbl_idx, 3);

    // Two taken updates on idx 3 (first one mispredicted)
    a_set(0, 5'd0, 1, 5'd3, 1, 0); tick();
    chk("a_novld_valid", a_pred_valid, 0);
    chk("a_hold_taken",  a_pred_taken, 0);
    chk("a_hold_idx",    a_pred_tbl_idx, 3);
    chk("a_miss1",       a_miss_count, 1);
    a_set(0, 5'd0, 1, 5'd3, 1, 1); tick();
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_trained_valid", a_pred_valid, 1);
    chk("a_trained_taken", a_pred_taken, 1);

    // Saturation at 3, then hysteresis
    repeat (3) begin a_set(0, 5'd0, 1, 5'd3, 1, 1); tick(); end
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_sat_taken", a_pred_taken, 1);
    a_set(0, 5'd0, 1, 5'd3, 0, 1); tick();
    chk("a_miss2", a_miss_count, 2);
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_hyst1_taken", a_pred_taken, 1);
    a_set(0, 5'd0, 1, 5'd3, 0, 1); tick();
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_hyst2_taken", a_pred_taken, 0);
    chk("a_miss3", a_miss_count, 3);

    // Forwarding on idx 7 (counter 1 -> 2)
    a_set(1, 5'd7, 1, 5'd7, 1, 0); tick();
    chk("a_fwd_taken", a_pred_taken, 1);
    chk("a_fwd_idx",   a_pred_tbl_idx, 7);
    chk("a_miss4",     a_miss_count, 4);

    // Independent read idx 9 while idx 7 decrements back to 1
    a_set(1, 5'd9, 1, 5'd7, 0, 1); tick();
    chk("a_indep_taken", a_pred_taken, 0);
    chk("a_indep_idx",   a_pred_tbl_idx, 9);
    chk("a_miss5",       a_miss_count, 5);
    a_set(1, 5'd7, 0, 5'd0, 0, 0); tick();
    chk("a_idx7_taken", a_pred_taken, 0);

    // Lower saturation on idx 9: 1 -> 0 -> 0 -> 1 -> 2
    a_set(0, 5'd0, 1, 5'd9, 0, 0); tick();
    a_set(0, 5'd0, 1, 5'd9, 0, 0); tick();
    a_set(0, 5'd0, 1, 5'd9, 1, 1); tick();
    a_set(1, 5'd9, 0, 5'd0, 0, 0); tick();
    chk("a_low_sat1", a_pred_taken, 0);
    a_set(0, 5'd0, 1, 5'd9, 1, 1); tick();
    a_set(1, 5'd9, 0, 5'd0, 0, 0); tick();
    chk("a_low_sat2", a_pred_taken, 1);

    // Retrain idx 3 to 3, then reset together with a read
    a_set(0, 5'd0, 1, 5'd3, 1, 1); tick();
    a_set(0, 5'd0, 1, 5'd3, 1, 1); tick();
    chk("a_miss_pre_rst", a_miss_count, 5);
    a_rst = 1'b1;
    a_set(1, 5'd3, 1, 5'd3, 1, 0); tick();
    chk("a_mid_rst_valid", a_pred_valid, 0);
    chk("a_mid_rst_taken", a_pred_taken, 0);
    chk("a_mid_rst_miss",  a_miss_count, 0);
    chk("a_mid_rst_ghr",   a_ghr, 0);
    a_rst = 1'b0;
    a_set(1, 5'd3, 0, 5'd0, 0, 0); tick();
    chk("a_post_rst_valid", a_pred_valid, 1);
    chk("a_post_rst_taken", a_pred_taken, 0);
    a_set(0, 5'd0, 0, 5'd0, 0, 0);

    // Gshare: history and saturating 2-bit miss counter
    b_rst = 1'b0;
    b_set(0, 5'd0, 1, 5'd0, 1, 1); tick();
    chk("b_ghr1", b_ghr, 3'b001);
    chk("b_miss0", b_miss_count, 0);
    b_set(0, 5'd0, 1, 5'd0, 1, 0); tick();
    chk("b_ghr2", b_ghr, 3'b011);
    chk("b_miss1", b_miss_count, 1);
    b_set(0, 5'd0, 1, 5'd0, 0, 1); tick();
    chk("b_ghr3", b_ghr, 3'b110);
    chk("b_miss2", b_miss_count, 2);
    // Read hashes with pre-update history 110
    b_set(1, 5'd1, 1, 5'd0, 1, 0); tick();
    chk("b_hash_valid", b_pred_valid, 1);
    chk("b_hash_idx",   b_pred_tbl_idx, 5'b00111);
    chk("b_hash_taken", b_pred_taken, 0);
    chk("b_ghr4",       b_ghr, 3'b101);
    chk("b_miss3",      b_miss_count, 3);
    b_set(0, 5'd0, 1, 5'd0, 0, 1); tick();
    chk("b_miss_sat", b_miss_count, 3);
    chk("b_ghr5",     b_ghr, 3'b010);
    b_set(0, 5'd0, 0, 5'd0, 0, 0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
